// File: rtl/fifo_drain_serializer.sv
// Pops FIFO words and shifts each out MSB-first on a valid/ready bit stream, counting drained words.
// Optional macro FIFO_DRAIN_PARITY_EN appends one even-parity beat to every frame.
module fifo_drain_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  EN,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  ser_data,
  output logic                  ser_valid,
  output logic                  ser_last,
  input  logic                  ser_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, WAIT = 2'd2, SHIFT = 2'd3} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [IW-1:0]         r_idx;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_xfer;
  logic                  w_last;
  logic                  w_end;
`ifdef FIFO_DRAIN_PARITY_EN
  logic                  r_par;
  logic                  r_par_beat;

  assign w_last = r_par_beat;
`else
  assign w_last = (r_idx == '0);
`endif

  // EN gates every transfer, so a stalled or disabled block never consumes a bit.
  assign w_xfer = EN && (r_state == SHIFT) && ser_ready;
  assign w_end  = w_xfer && w_last;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Holding in POP while EN=0 defers the RD strobe instead of dropping it.
  always_comb begin
    w_next = r_state;
    if (EN) begin
      case (r_state)
        IDLE:    if (!fifo_empty) w_next = POP;
        POP:     w_next = WAIT;
        WAIT:    w_next = SHIFT;
        SHIFT:   if (w_end) w_next = fifo_empty ? IDLE : POP;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_shreg    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
`ifdef FIFO_DRAIN_PARITY_EN
      r_par      <= 1'b0;
      r_par_beat <= 1'b0;
`endif
    end else if (EN) begin
      if (r_state == WAIT) begin
        r_shreg    <= fifo_data;
        r_idx      <= IW'(DATA_WIDTH - 1);
`ifdef FIFO_DRAIN_PARITY_EN
        r_par      <= ^fifo_data;
        r_par_beat <= 1'b0;
`endif
      end
      if (w_xfer) begin
        r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
        if (r_idx != '0) r_idx <= r_idx - IW'(1);
`ifdef FIFO_DRAIN_PARITY_EN
        if (r_idx == '0 && !r_par_beat) r_par_beat <= 1'b1;
`endif
      end
      if (w_end) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
`ifdef FIFO_DRAIN_PARITY_EN
        r_par_beat <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    fifo_rd    = EN && (r_state == POP);
    ser_valid  = EN && (r_state == SHIFT);
    ser_last   = (r_state == SHIFT) && w_last;
    busy       = (r_state != IDLE);
    word_count = r_cnt;
`ifdef FIFO_DRAIN_PARITY_EN
    ser_data   = r_par_beat ? r_par : r_shreg[DATA_WIDTH-1];
`else
    ser_data   = r_shreg[DATA_WIDTH-1];
`endif
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: queue-based FIFO model plus frame scoreboard, directed and random traffic.
module tb_fifo_drain_serializer;

  localparam int DW = 32;
  localparam int CW = 16;
`ifdef FIFO_DRAIN_PARITY_EN
  localparam int FRAME = DW + 1;
`else
  localparam int FRAME = DW;
`endif

  logic          Clk = 1'b0;
  logic          Rst, EN, fifo_empty, ser_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd, ser_data, ser_valid, ser_last, busy;
  logic [CW-1:0] word_count;

  always #5 Clk = ~Clk;

  fifo_drain_serializer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .EN(EN), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .ser_data(ser_data), .ser_valid(ser_valid), .ser_last(ser_last),
    .ser_ready(ser_ready), .busy(busy), .word_count(word_count)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic [31:0] popped[$];
  int          rd_times[$];
  logic [63:0] rx;
  int          nbits, exp_cnt, n_rd, cyc_no, nvld, frame_vld, mode, to_push;
  logic        s_rd, s_vld, s_dat, s_last, s_rdy, s_en, s_rst, s_empty, p_stall, p_dat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample outputs at negedge, then advance the FIFO and scoreboard after the edge.
  task automatic cyc();
    logic [31:0] w;
    @(negedge Clk);
    s_rd = fifo_rd; s_vld = ser_valid; s_dat = ser_data; s_last = ser_last;
    s_rdy = ser_ready; s_en = EN; s_rst = Rst; s_empty = fifo_empty;
    if (!s_rst && !s_en) begin
      chk("en0_valid", s_vld, 0);
      chk("en0_rd", s_rd, 0);
    end
    if (!s_rst && s_rd) chk("rd_when_empty", s_empty, 0);
    if (p_stall && s_en && !s_rst) begin
      chk("stall_valid", s_vld, 1);
      chk("stall_data", s_dat, p_dat);
    end
    p_stall = s_en && s_vld && !s_rdy && !s_rst;
    p_dat   = s_dat;
    @(posedge Clk);
    #1;
    cyc_no++;
    if (s_rst) begin
      exp_cnt = 0; nbits = 0; rx = '0; nvld = 0;
      popped.delete();
      p_stall = 1'b0;
    end else begin
      if (s_rd) begin
        n_rd++;
        rd_times.push_back(cyc_no);
        if (q.size() > 0) begin
          fifo_data = q.pop_front();
          popped.push_back(fifo_data);
        end
      end
      if (s_vld) nvld++;
      if (s_vld && s_rdy) begin
        rx = {rx[62:0], s_dat};
        nbits++;
        chk("last_marker", s_last, (nbits == FRAME));
        if (nbits == FRAME) begin
          exp_cnt++;
          frame_vld = nvld;
          if (popped.size() == 0) begin
            chk("frame_without_pop", 1, 0);
          end else begin
            w = popped.pop_front();
`ifdef FIFO_DRAIN_PARITY_EN
            chk("frame_word", rx[32:1], w);
            chk("parity_bit", rx[0], ^w);
`else
            chk("frame_word", rx[31:0], w);
`endif
          end
          nbits = 0; rx = '0; nvld = 0;
        end
      end
    end
    fifo_empty = (q.size() == 0);
    chk("word_count", word_count, 64'(exp_cnt % 65536));
  endtask

  task automatic drive();
    case (mode)
      1: begin
        ser_ready = ($urandom_range(0, 9) < 7);
        EN        = ($urandom_range(0, 9) != 0);
      end
      2: begin
        EN        = 1'b1;
        ser_ready = (nvld % 2 == 1);
      end
      default: begin
        EN        = 1'b1;
        ser_ready = 1'b1;
      end
    endcase
  endtask

  task automatic run_words(input int target, input int budget);
    int n;
    n = 0;
    while (!(exp_cnt >= target && to_push == 0 && q.size() == 0 && busy == 1'b0) && n < budget) begin
      if (to_push > 0 && $urandom_range(0, 3) == 0) begin
        push($urandom);
        to_push--;
      end
      drive();
      cyc();
      n++;
    end
    if (n >= budget) chk("run_timeout", n, 0);
  endtask

  initial begin
    int n;
    logic fd, fb;
    logic [CW-1:0] fc;
    Rst = 1'b1; EN = 1'b0; ser_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    p_stall = 1'b0; p_dat = 1'b0; rx = '0;
    nbits = 0; exp_cnt = 0; n_rd = 0; cyc_no = 0; nvld = 0; frame_vld = 0; mode = 0; to_push = 0;
    repeat (3) cyc();
    Rst = 1'b0; EN = 1'b1;
    chk("rst_rd", fifo_rd, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_last", ser_last, 0);
    chk("rst_data", ser_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", word_count, 0);

    // Single word, free-running sink.
    n = n_rd;
    push(32'hA5A5_0F0F);
    run_words(1, 200);
    chk("t1_rd_pulses", n_rd - n, 1);
    chk("t1_idle", busy, 0);

    // Three queued words drain back to back.
    rd_times.delete();
    push(32'h0000_0001); push(32'h8000_0000); push(32'hFFFF_FFFF);
    run_words(4, 400);
    chk("t2_rd_pulses", rd_times.size(), 3);
    if (rd_times.size() == 3) begin
      chk("t2_gap1", rd_times[1] - rd_times[0], FRAME + 2);
      chk("t2_gap2", rd_times[2] - rd_times[1], FRAME + 2);
    end

    // Sink stalls every other SHIFT cycle.
    mode = 2;
    push(32'hDEAD_BEEF);
    run_words(5, 400);
    chk("t3_shift_cycles", frame_vld, 2 * FRAME);
    mode = 0;

    // Empty FIFO for 20 cycles, then a word arrives.
    EN = 1'b1; ser_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t4_no_rd", s_rd, 0);
      chk("t4_not_busy", busy, 0);
    end
    push(32'h0000_0007);
    n = 0;
    while (n < 10) begin
      cyc();
      if (s_rd) break;
      n++;
    end
    chk("t4_pop_delay", n, 1);
    run_words(6, 200);

    // Freeze at bit index 10, then reset mid-frame.
    push($urandom);
    n = 0;
    while (nbits < 21 && n < 100) begin
      cyc();
      n++;
    end
    chk("t5_reached_idx10", nbits, 21);
    fd = ser_data; fb = busy; fc = word_count;
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_frozen_data", ser_data, fd);
      chk("t5_frozen_busy", busy, fb);
      chk("t5_frozen_count", word_count, fc);
    end
    Rst = 1'b1; EN = 1'b1;
    cyc();
    Rst = 1'b0;
    chk("t5_rst_valid", ser_valid, 0);
    chk("t5_rst_count", word_count, 0);
    chk("t5_rst_idle", busy, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t5_no_rd", s_rd, 0);
    end

    // Random words, random stalls and enable drops.
    mode = 1;
    to_push = 30;
    run_words(30, 6000);
    mode = 0;
    EN = 1'b1;
    chk("t6_total", exp_cnt, 30);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
